// File: rtl/cacheline_mem_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory signals around cacheline_mem_arbiter.
// slave = arbiter view, master = the caches/memory surrounding it.
interface cacheline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // Request/response protocol: a cache raises read/write with a stable address
  // (and write data) and holds it until its resp pulse; it drops the request the
  // cycle after resp. Memory answers each strobe with a single-cycle mem_resp,
  // and mem_rdata is valid in that same cycle.
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline memory port between icache and dcache, one transaction at a time,
// alternating priority on conflicts. Define ARB_PERF_CNT_EN to build the perf counters.
module cacheline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  cacheline_mem_arbiter_if.slave bus,
  output logic [31:0]            perf_i_grants,
  output logic [31:0]            perf_d_grants,
  output logic [31:0]            perf_conflicts,
  output logic [1:0]             state
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  logic [1:0]        state_q;
  logic              last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              read_q;
  logic              write_q;
  logic              i_pend;
  logic              d_pend;
  logic              grant_i;
  logic              grant_d;
  logic              done;

  assign i_pend  = bus.i_read;
  assign d_pend  = bus.d_read | bus.d_write;
  // On a tie the requester that did not win last time goes first.
  assign grant_d = (state_q == IDLE) && d_pend && (!i_pend || !last_d);
  assign grant_i = (state_q == IDLE) && i_pend && !grant_d;
  assign done    = (state_q != IDLE) && bus.mem_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_d  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (grant_d) begin
      state_q <= D_BUSY;
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_wdata;
      write_q <= bus.d_write;
      read_q  <= !bus.d_write;
      last_d  <= 1'b1;
    end else if (grant_i) begin
      state_q <= I_BUSY;
      addr_q  <= bus.i_addr;
      read_q  <= 1'b1;
      write_q <= 1'b0;
      last_d  <= 1'b0;
    end else if (done) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = read_q;
  assign bus.mem_write = write_q;
  assign bus.i_resp    = bus.mem_resp && (state_q == I_BUSY);
  assign bus.d_resp    = bus.mem_resp && (state_q == D_BUSY);
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign state         = state_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_cnt;
  logic [31:0] d_cnt;
  logic [31:0] c_cnt;
  logic        conflict;

  assign conflict = ((state_q == I_BUSY) && d_pend) || ((state_q == D_BUSY) && i_pend) ||
                    ((state_q == IDLE) && i_pend && d_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= '0;
      d_cnt <= '0;
      c_cnt <= '0;
    end else begin
      if (grant_i && (i_cnt != 32'hFFFF_FFFF)) i_cnt <= i_cnt + 32'd1;
      if (grant_d && (d_cnt != 32'hFFFF_FFFF)) d_cnt <= d_cnt + 32'd1;
      if (conflict && (c_cnt != 32'hFFFF_FFFF)) c_cnt <= c_cnt + 32'd1;
    end
  end

  assign perf_i_grants  = i_cnt;
  assign perf_d_grants  = d_cnt;
  assign perf_conflicts = c_cnt;
`else
  assign perf_i_grants  = 32'd0;
  assign perf_d_grants  = 32'd0;
  assign perf_conflicts = 32'd0;
`endif
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: directed scenarios plus random cache/memory traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_cacheline_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic        clk;
  logic        rst;
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_conflicts;
  logic [1:0]  state;

  cacheline_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cacheline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts),
    .state          (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // reference model: who owns the memory port, what it asked for, who won last
  int                m_owner;   // 0 none, 1 icache, 2 dcache
  logic              m_last_d;
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr;
  logic [LINE_W-1:0] m_wdata;
  logic [31:0]       m_gi, m_gd, m_conf;

  // samples from the most recent negedge
  logic              s_mem_read, s_mem_write, s_i_resp, s_d_resp;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [LINE_W-1:0] s_mem_wdata;

  logic [ADDR_W-1:0] exp_q[$];

  task automatic model_reset();
    m_owner  = 0;
    m_last_d = 1'b0;
    m_gi     = '0;
    m_gd     = '0;
    m_conf   = '0;
  endtask

  task automatic check_perf(input string tag);
`ifdef ARB_PERF_CNT_EN
    check({tag, "_perf_i"}, perf_i_grants, m_gi);
    check({tag, "_perf_d"}, perf_d_grants, m_gd);
    check({tag, "_perf_c"}, perf_conflicts, m_conf);
`else
    check({tag, "_perf_i"}, perf_i_grants, 0);
    check({tag, "_perf_d"}, perf_d_grants, 0);
    check({tag, "_perf_c"}, perf_conflicts, 0);
`endif
  endtask

  // Sample at negedge, compare with the model, advance the model, return at the next drive point.
  task automatic step();
    logic i_p, d_p;
    @(negedge clk);
    s_mem_read  = bus.mem_read;
    s_mem_write = bus.mem_write;
    s_mem_addr  = bus.mem_addr;
    s_mem_wdata = bus.mem_wdata;
    s_i_resp    = bus.i_resp;
    s_d_resp    = bus.d_resp;
    if (rst) begin
      model_reset();
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_write", bus.mem_write, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_resp", {bus.i_resp, bus.d_resp}, 0);
      check_perf("rst");
    end else begin
      check("mem_read", bus.mem_read, (m_owner == 1) || (m_owner == 2 && !m_wr));
      check("mem_write", bus.mem_write, (m_owner == 2) && m_wr);
      if (m_owner != 0) check("mem_addr", bus.mem_addr, m_addr);
      if (m_owner == 2 && m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
      check("i_resp", bus.i_resp, bus.mem_resp && (m_owner == 1));
      check("d_resp", bus.d_resp, bus.mem_resp && (m_owner == 2));
      check("i_rdata", bus.i_rdata, bus.mem_rdata);
      check("d_rdata", bus.d_rdata, bus.mem_rdata);
      check_perf("run");
      i_p = bus.i_read;
      d_p = bus.d_read | bus.d_write;
      if ((m_owner == 1 && d_p) || (m_owner == 2 && i_p) || (m_owner == 0 && i_p && d_p))
        m_conf = sat_inc(m_conf);
      if (m_owner == 0) begin
        if (d_p && (!i_p || !m_last_d)) begin
          m_owner = 2; m_addr = bus.d_addr; m_wr = bus.d_write; m_wdata = bus.d_wdata;
          m_last_d = 1'b1; m_gd = sat_inc(m_gd);
        end else if (i_p) begin
          m_owner = 1; m_addr = bus.i_addr; m_last_d = 1'b0; m_gi = sat_inc(m_gi);
        end
      end else if (bus.mem_resp) begin
        m_owner = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_addr = '0; bus.i_read = 1'b0;
    bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
  endtask

  initial begin
    logic [LINE_W-1:0] wd;
    logic [31:0] gi0, gd0;
    logic prev_strobe;
    int n_resp, cyc;
    logic [ADDR_W-1:0] e;
    logic [1:0] op;

    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    step();

    // single icache read
    bus.i_addr = 32'h0000_1000; bus.i_read = 1'b1;
    step(); check("t1_no_strobe_yet", s_mem_read, 0);
    step(); check("t1_mem_read", s_mem_read, 1); check("t1_mem_addr", s_mem_addr, 32'h1000);
    repeat (3) step();
    bus.mem_rdata = {32{8'hA5}}; bus.mem_resp = 1'b1;
    step();
    check("t1_i_resp", s_i_resp, 1); check("t1_d_resp", s_d_resp, 0);
    check("t1_i_rdata", bus.i_rdata, {32{8'hA5}});
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    step();

    // simultaneous requests straight after reset: dcache first
    rst = 1'b1; step(); rst = 1'b0;
    wd = rand_line();
    bus.i_addr = 32'h2000; bus.i_read = 1'b1;
    bus.d_addr = 32'h3000; bus.d_write = 1'b1; bus.d_wdata = wd;
    step();
    step();
    check("t2_d_first_wr", s_mem_write, 1); check("t2_d_first_rd", s_mem_read, 0);
    check("t2_wdata", s_mem_wdata, wd); check("t2_addr", s_mem_addr, 32'h3000);
    bus.mem_resp = 1'b1; step(); check("t2_d_resp", s_d_resp, 1);
    bus.mem_resp = 1'b0; bus.d_write = 1'b0;
    step(); check("t2_gap", s_mem_read, 0);
    step(); check("t2_i_read", s_mem_read, 1); check("t2_i_addr", s_mem_addr, 32'h2000);
    bus.mem_resp = 1'b1; step(); check("t2_i_resp", s_i_resp, 1);
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    step();

    // alternation with both held (dcache uses read+write together)
    gi0 = perf_i_grants; gd0 = perf_d_grants;
    exp_q = {32'h5000, 32'h4000, 32'h5000, 32'h4000};
    bus.i_addr = 32'h4000; bus.i_read = 1'b1;
    bus.d_addr = 32'h5000; bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_wdata = rand_line();
    prev_strobe = 1'b0; n_resp = 0; cyc = 0;
    while (n_resp < 4 && cyc < 60) begin
      step(); cyc++;
      if ((s_mem_read | s_mem_write) && !prev_strobe && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("t3_grant_order", s_mem_addr, e);
        if (e == 32'h5000) begin
          check("t4_rw_write", s_mem_write, 1); check("t4_rw_read", s_mem_read, 0);
        end
      end
      prev_strobe = s_mem_read | s_mem_write;
      if (s_i_resp || s_d_resp) n_resp++;
      bus.mem_resp = prev_strobe && !bus.mem_resp;
    end
    check("t3_resp_count", n_resp, 4);
    check("t3_queue_empty", exp_q.size(), 0);
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.mem_resp = 1'b0;
    step();
`ifdef ARB_PERF_CNT_EN
    check("t3_perf_i_delta", perf_i_grants - gi0, 2);
    check("t3_perf_d_delta", perf_d_grants - gd0, 2);
`endif

    // stray response while idle
    bus.mem_resp = 1'b1; step();
    check("t5_i_resp", s_i_resp, 0); check("t5_d_resp", s_d_resp, 0);
    bus.mem_resp = 1'b0; step();
    check("t5_idle_rd", s_mem_read, 0); check("t5_idle_wr", s_mem_write, 0);

    // asynchronous reset in the middle of a dcache write
    bus.d_addr = 32'h6000; bus.d_write = 1'b1; bus.d_wdata = rand_line();
    step(); step();
    check("t6_busy_wr", s_mem_write, 1);
    #2 rst = 1'b1;
    #1 check("t6_async_wr_drop", bus.mem_write, 0);
    model_reset();
    bus.d_write = 1'b0;
    step();
    rst = 1'b0;
    bus.mem_resp = 1'b1; step(); check("t6_no_d_resp", s_d_resp, 0);
    bus.mem_resp = 1'b0;
    bus.i_addr = 32'h7000; bus.i_read = 1'b1;
    bus.d_addr = 32'h8000; bus.d_read = 1'b1;
    step(); step();
    check("t6_d_first_addr", s_mem_addr, 32'h8000); check("t6_d_first_rd", s_mem_read, 1);
    bus.mem_resp = 1'b1; step(); check("t6_d_resp", s_d_resp, 1);
    bus.mem_resp = 1'b0; bus.d_read = 1'b0;
    step(); step();
    check("t6_then_i_addr", s_mem_addr, 32'h7000);
    bus.mem_resp = 1'b1; step(); check("t6_i_resp", s_i_resp, 1);
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    step();

    // random traffic from both caches, memory with random latency and stray responses
    for (int c = 0; c < 3000; c++) begin
      if (bus.i_read) begin
        if (s_i_resp) bus.i_read = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.i_read = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFE0;
      end
      if (bus.d_read | bus.d_write) begin
        if (s_d_resp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      end else if ($urandom_range(0, 3) == 0) begin
        op = 2'($urandom_range(1, 3));
        bus.d_read = op[0]; bus.d_write = op[1];
        bus.d_addr = $urandom & 32'hFFFF_FFE0; bus.d_wdata = rand_line();
      end
      if (bus.mem_resp) begin
        bus.mem_resp = 1'b0;
      end else if ((s_mem_read | s_mem_write) && $urandom_range(0, 2) == 0) begin
        bus.mem_resp = 1'b1; bus.mem_rdata = rand_line();
      end else if ($urandom_range(0, 40) == 0) begin
        bus.mem_resp = 1'b1; bus.mem_rdata = rand_line();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
